if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage directly upstream of the IF/ID pipeline register. Holds the program counter, issues single-outstanding requests to instruction memory over a valid/ready request and valid-only response interface, and presents the fetched instruction on IF_pc/IF_inst. It also applies branch/jump redirects from EX and honours the hazard unit's freeze. While no instruction is ready, it drives an all-zero bubble, which IF/ID captures like a flush.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- redirect_valid  in  1  taken branch/jump resolved in EX this cycle.
- redirect_pc  in  32  target PC; bits [1:0] ignored, treated as 00.
- freeze  in  1  hazard-unit stall; same signal that freezes IF/ID.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_addr  out  32  fetch address, word aligned.
- imem_rsp_valid  in  1  response data valid (1+ cycles after acceptance).
- imem_rsp_data  in  32  instruction word.
- flush_o  out  1  flush to IF/ID; equals redirect_valid (combinational).
- IF_pc  out  32  PC of presented instruction; 0 when IF_valid=0.
- IF_inst  out  32  presented instruction; 0 (bubble) when IF_valid=0.
- IF_valid  out  1  IF_pc/IF_inst hold a real instruction.

## Operation
- State machine has four states:
  - FETCH: send a request.
  - WAIT: request accepted, response pending.
  - VALID: instruction in the output register.
  - DROP: stale response pending after a redirect.
- imem_req_valid = (state==FETCH); imem_addr = pc. Both are combinational from registers.
- FETCH: on req_valid&req_ready go to WAIT. Otherwise stay and hold the address.
- WAIT: on rsp_valid, load IF_inst<=rsp_data, IF_pc<=pc, IF_valid<=1, pc<=pc+4, and go to VALID.
- VALID: with freeze=1, hold all outputs. With freeze=0, IF/ID consumes at this edge; clear the output register to the bubble and go to FETCH.
- DROP: on rsp_valid, discard the data and go to FETCH.
- Redirect (highest priority, overrides freeze and every state transition):
  - Always: pc<=redirect_pc&~3, output register cleared to the bubble.
  - Next state is DROP if a response is outstanding (state WAIT, state DROP, or FETCH with handshake this cycle without a simultaneous rsp). Otherwise next state is FETCH.
- Redirect in FETCH without handshake: the request is withdrawn, and the new address appears next cycle.
- Redirect in WAIT coincident with rsp_valid: the response is discarded and next state is FETCH.
- rsp_valid in FETCH or VALID is ignored; this covers responses to requests issued before reset.
- pc+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 0.

## Timing
- Reset values: state FETCH, pc=RESET_PC, IF_pc=0, IF_inst=0, IF_valid=0. imem_req_valid=1 in the first cycle after reset release.
- Request accepted at edge N; response sampled at edge M>N; IF_valid high from M to the consuming edge.
- Minimum 3 cycles per instruction with 1-cycle memory: FETCH, WAIT, VALID.
- flush_o has zero latency; IF_* outputs are registered.
- Never more than one request outstanding.

## Structure
- Shared package if_pkg holds:
  - fetch_state_t enum {FETCH, WAIT, DROP, VALID};
  - BUBBLE_INST = 32'h0000_0000;
  - PC_STEP = 32'd4.
- Single module; no sub-module.

## Test plan
- Reset, RESET_PC=32'h100, 1-cycle memory returning 32'hAAAA0001 -> addr 0x100 in cycle 1; IF_valid=1, IF_pc=0x100, IF_inst=32'hAAAA0001 in cycle 3; next addr 0x104.
- freeze=1 held 4 cycles while VALID -> outputs unchanged; no imem_req_valid; fetch of 0x104 begins the cycle after freeze drops.
- Redirect to 32'h203 while WAIT, response arrives 2 cycles later -> flush_o=1 that cycle; response dropped; next request addr 0x200; no IF_valid for the dropped word.
- imem_req_ready=0 for 3 cycles -> imem_addr stable, IF_valid=0, IF_inst=0 throughout.
- pc=32'hFFFF_FFFC, fetch completes -> next imem_addr=0.
- rst asserted mid-WAIT, released, stale rsp_valid in first FETCH cycle -> ignored; outputs stay 0; addr=RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction-fetch stage
// Purpose: fetch FSM state encoding, bubble instruction and PC increment.
// Ports: none (package).
package if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request presented to instruction memory
    WAIT  = 2'd1,  // request accepted, response pending
    DROP  = 2'd2,  // stale response pending after a redirect
    VALID = 2'd3   // instruction held in the output register
  } fetch_state_t;

  localparam logic [31:0] BUBBLE_INST = 32'h0000_0000;
  localparam logic [31:0] PC_STEP     = 32'd4;

endpackage

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage with single-outstanding imem access
// Purpose: holds the PC, fetches one instruction at a time and presents it to IF/ID,
//          applying EX redirects and the hazard-unit freeze.
// Ports:
//   clk, rst (async, active-low)       clock and reset
//   redirect_valid, redirect_pc        taken branch/jump from EX
//   freeze                             hazard stall, shared with IF/ID
//   imem_req_valid/ready, imem_addr    fetch request handshake
//   imem_rsp_valid, imem_rsp_data      fetch response (valid only)
//   flush_o                            flush to IF/ID (combinational)
//   IF_pc, IF_inst, IF_valid           presented instruction, zero bubble when invalid
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        freeze,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        flush_o,
  output logic [31:0] IF_pc,
  output logic [31:0] IF_inst,
  output logic        IF_valid
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_inst_q, if_inst_d;
  logic         if_valid_q, if_valid_d;

  logic         req_fire;
  logic         rsp_owed;

  assign req_fire = (state_q == FETCH) && imem_req_ready;

  // A redirect must still swallow the response of any request already accepted,
  // including one accepted at this very edge, unless that response lands now.
  assign rsp_owed = ((state_q == WAIT) || (state_q == DROP) || req_fire) && !imem_rsp_valid;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      if_pc_q    <= 32'h0000_0000;
      if_inst_q  <= BUBBLE_INST;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;

    case (state_q)
      FETCH: begin
        if (req_fire) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if_inst_d  = imem_rsp_data;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + PC_STEP;
          state_d    = VALID;
        end
      end
      VALID: begin
        // Without freeze IF/ID takes the instruction at this edge.
        if (!freeze) begin
          if_pc_d    = 32'h0000_0000;
          if_inst_d  = BUBBLE_INST;
          if_valid_d = 1'b0;
          state_d    = FETCH;
        end
      end
      DROP: begin
        if (imem_rsp_valid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Redirect overrides freeze and every transition above.
    if (redirect_valid) begin
      pc_d       = redirect_pc & ~32'h3;
      if_pc_d    = 32'h0000_0000;
      if_inst_d  = BUBBLE_INST;
      if_valid_d = 1'b0;
      state_d    = rsp_owed ? DROP : FETCH;
    end
  end

  // Outputs
  always_comb begin
    imem_req_valid = (state_q == FETCH);
    imem_addr      = pc_q;
    flush_o        = redirect_valid;
    IF_pc          = if_pc_q;
    IF_inst        = if_inst_q;
    IF_valid       = if_valid_q;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - randomized scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        freeze = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        flush_o;
  logic [31:0] IF_pc;
  logic [31:0] IF_inst;
  logic        IF_valid;

  if_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .freeze         (freeze),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .flush_o        (flush_o),
    .IF_pc          (IF_pc),
    .IF_inst        (IF_inst),
    .IF_valid       (IF_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   first_cyc = -1;
  int   rel_cyc = 0;

  // stimulus knobs and memory / program-order model
  int          p_frz = 0, p_redir = 0, p_rdy = 0, lat_min = 1, lat_max = 1;
  logic        force_redir = 1'b0;
  logic [31:0] force_pc = 32'h0;
  logic        mem_pending = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] exp_addr = 32'h100;
  logic        last_hs = 1'b0;
  logic        prev_req = 1'b0, prev_rdy = 1'b0, prev_redir = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hAAAA_0001;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // One cycle of stimulus, called at a falling edge.
  task automatic step();
    exp_t e;
    if (prev_req && !prev_rdy && !prev_redir) begin
      chk("req_held", {31'b0, imem_req_valid}, 32'd1);
      chk("addr_held", imem_addr, prev_addr);
    end
    if (mem_pending && imem_req_valid)
      chk("single_outstanding", {31'b0, imem_req_valid}, 32'd0);

    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (mem_pending) begin
      if (mem_cnt <= 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr);
        mem_pending    = 1'b0;
      end else begin
        mem_cnt--;
      end
    end

    freeze         = (int'($urandom_range(99)) < p_frz);
    redirect_valid = force_redir || (int'($urandom_range(99)) < p_redir);
    redirect_pc    = force_redir ? force_pc : $urandom;
    force_redir    = 1'b0;
    imem_req_ready = (int'($urandom_range(99)) < p_rdy);

    last_hs = imem_req_valid && imem_req_ready;
    if (last_hs) begin
      chk("req_addr", imem_addr, exp_addr);
      mem_pending = 1'b1;
      mem_cnt     = int'($urandom_range(lat_max, lat_min));
      mem_addr    = imem_addr;
      e.pc   = exp_addr;
      e.inst = mem_word(exp_addr);
      sb_q.push_back(e);
      exp_addr = exp_addr + 32'd4;
    end
    // A redirect kills everything not yet presented.
    if (redirect_valid) begin
      sb_q.delete();
      exp_addr = redirect_pc & ~32'h3;
    end

    prev_req   = imem_req_valid;
    prev_rdy   = imem_req_ready;
    prev_redir = redirect_valid;
    prev_addr  = imem_addr;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      step();
    end
  endtask

  // Returns at a falling edge with IF_valid=1 and no step issued yet.
  task automatic wait_valid(input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (IF_valid) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk(name, {31'b0, seen}, 32'd1);
  endtask

  task automatic wait_hs(input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      step();
      if (last_hs) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, {31'b0, seen}, 32'd1);
  endtask

  // Monitor: samples just after each rising edge, pops expectations on presentation.
  initial begin
    logic        pv;
    logic [31:0] ppc, pinst;
    exp_t        e;
    pv = 1'b0; ppc = 32'h0; pinst = 32'h0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst) begin
        pv = 1'b0;
        continue;
      end
      chk("flush_o", {31'b0, flush_o}, {31'b0, redirect_valid});
      if (!IF_valid) begin
        chk("bubble_pc", IF_pc, 32'h0);
        chk("bubble_inst", IF_inst, 32'h0);
      end else begin
        chk("no_req_while_valid", {31'b0, imem_req_valid}, 32'd0);
      end
      if (pv) begin
        if (redirect_valid) begin
          chk("redirect_clears", {31'b0, IF_valid}, 32'd0);
        end else if (freeze) begin
          chk("freeze_valid", {31'b0, IF_valid}, 32'd1);
          chk("freeze_pc", IF_pc, ppc);
          chk("freeze_inst", IF_inst, pinst);
        end else begin
          chk("consume_valid", {31'b0, IF_valid}, 32'd0);
          chk("consume_refetch", {31'b0, imem_req_valid}, 32'd1);
        end
      end else if (IF_valid) begin
        if (sb_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_inst actual pc=%h inst=%h expected none", IF_pc, IF_inst);
        end else begin
          e = sb_q.pop_front();
          chk("inst_pc", IF_pc, e.pc);
          chk("inst_word", IF_inst, e.inst);
        end
        if (first_cyc < 0) first_cyc = cyc;
      end
      pv = IF_valid; ppc = IF_pc; pinst = IF_inst;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_if_valid", {31'b0, IF_valid}, 32'd0);
    chk("rst_if_pc", IF_pc, 32'h0);
    chk("rst_if_inst", IF_inst, 32'h0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("rst_addr", imem_addr, 32'h100);

    // 1-cycle memory, always ready: FETCH, WAIT, VALID
    p_rdy = 100; lat_min = 1; lat_max = 1;
    rel_cyc = cyc;
    rst = 1'b1;
    step();
    run(6);
    chk("first_latency", first_cyc - rel_cyc, 32'd2);

    // freeze held 4 cycles while VALID
    wait_valid("wait_valid_freeze");
    p_frz = 100;
    step();
    run(3);
    @(negedge clk);
    chk("freeze4_valid", {31'b0, IF_valid}, 32'd1);
    chk("freeze4_noreq", {31'b0, imem_req_valid}, 32'd0);
    p_frz = 0;
    step();
    @(negedge clk);
    chk("fetch_after_freeze", {31'b0, imem_req_valid}, 32'd1);
    step();

    // redirect to 0x203 while WAIT, slow response
    lat_min = 3; lat_max = 3;
    wait_hs("wait_hs_redirect");
    @(negedge clk);
    force_redir = 1'b1;
    force_pc    = 32'h0000_0203;
    step();
    #1;
    chk("flush_on_redirect", {31'b0, flush_o}, 32'd1);
    lat_min = 1; lat_max = 1;
    wait_valid("wait_valid_target");
    chk("redirect_target_pc", IF_pc, 32'h200);

    // wrap of pc+4
    force_redir = 1'b1;
    force_pc    = 32'hFFFF_FFFC;
    step();
    wait_valid("wait_valid_wrap");
    chk("wrap_pc", IF_pc, 32'hFFFF_FFFC);
    step();
    @(negedge clk);
    chk("wrap_addr", imem_addr, 32'h0);

    // ready low for 3 cycles
    p_rdy = 0;
    step();
    run(3);
    chk("stall_addr", imem_addr, 32'h0);
    chk("stall_valid", {31'b0, IF_valid}, 32'd0);
    p_rdy = 100;

    // reset in WAIT, stale response right after release
    lat_min = 3; lat_max = 3;
    wait_hs("wait_hs_reset");
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    exp_addr = 32'h100; mem_pending = 1'b0; prev_req = 1'b0;
    freeze = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("stale_valid", {31'b0, IF_valid}, 32'd0);
    chk("stale_inst", IF_inst, 32'h0);
    chk("stale_req", {31'b0, imem_req_valid}, 32'd1);
    chk("stale_addr", imem_addr, 32'h100);
    step();

    // random traffic
    p_frz = 30; p_redir = 5; p_rdy = 60; lat_min = 1; lat_max = 3;
    run(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
